// File: rtl/key_pkg.sv
// key_pkg: shared definitions for the push-button front end.
//   key_state_e : per-key debounce FSM state encoding
//   SW_RST      : speed select value after reset
//   DIR_RST     : direction value after reset (1 = rotate left)
package key_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_state_e;

   localparam logic [1:0] SW_RST  = 2'b01;
   localparam logic       DIR_RST = 1'b1;

endpackage

// File: rtl/key_debounce.sv
// key_debounce: one push button's synchroniser, debounce FSM and hold timer.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   key_n      : raw active-low button, asynchronous and bouncing
//   press      : one-cycle pulse when a press has been stable DEBOUNCE_CNT clocks
//   long_press : one-cycle pulse when the accepted press has been held LONG_CNT clocks
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned LONG_CNT     = 50_000_000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press,
   output logic long_press
);

   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CNT);

   logic [1:0]       sync_q, sync_d;
   key_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hold_q, hold_d;
   logic             press_q, press_d;
   logic             long_q, long_d;
   logic             k;

   // Synchroniser resets to "released" so a held key is re-debounced after reset.
   assign sync_d = {sync_q[0], key_n};
   assign k      = ~sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         state_q <= IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         press_q <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         press_q <= press_d;
         long_q  <= long_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      press_d = 1'b0;
      long_d  = 1'b0;
      case (state_q)
         IDLE: begin
            hold_d = '0;
            if (k) begin
               state_d = PRESS_WAIT;
               cnt_d   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!k) begin
               state_d = IDLE;
            end else if (cnt_q == DEB_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               press_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         PRESSED: begin
            if (!k) begin
               state_d = RELEASE_WAIT;
               cnt_d   = '0;
            end else if (hold_q != LONG_MAX) begin
               // Saturating hold: the long pulse fires only on the step into LONG_CNT-1.
               hold_d = hold_q + 1'b1;
               long_d = (hold_d == LONG_LAST);
            end
         end
         RELEASE_WAIT: begin
            // Hold counter is kept here so a release bounce cannot re-arm the long pulse.
            if (k) begin
               state_d = PRESSED;
            end else if (cnt_q == DEB_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
               hold_d  = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign press      = press_q;
   assign long_press = long_q;

endmodule

// File: rtl/key_ctrl.sv
// key_ctrl: two-key front end for the LED rotator.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   key_n     : raw active-low buttons
//   sw        : speed select; key 0 press steps it, key 0 long press forces 2'b00
//   dir       : rotate direction (1 = left); key 1 press toggles it
//   key_press : one-cycle accepted-press pulse per key
//   key_long  : one-cycle long-press pulse per key
module key_ctrl
   import key_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = 1_000_000,
   parameter int unsigned LONG_CNT     = 50_000_000,
   parameter int unsigned CNT_W        = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] key_n,
   output logic [1:0] sw,
   output logic       dir,
   output logic [1:0] key_press,
   output logic [1:0] key_long
);

   logic [1:0] sw_q, sw_d;
   logic       dir_q, dir_d;

   key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .LONG_CNT     (LONG_CNT),
      .CNT_W        (CNT_W)
   ) u_key0 (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[0]),
      .press      (key_press[0]),
      .long_press (key_long[0])
   );

   key_debounce #(
      .DEBOUNCE_CNT (DEBOUNCE_CNT),
      .LONG_CNT     (LONG_CNT),
      .CNT_W        (CNT_W)
   ) u_key1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_n      (key_n[1]),
      .press      (key_press[1]),
      .long_press (key_long[1])
   );

   always_comb begin
      sw_d  = sw_q;
      dir_d = dir_q;
      if (key_long[0]) begin
         sw_d = 2'b00;
      end else if (key_press[0]) begin
         sw_d = sw_q + 2'b01;
      end
      if (key_press[1]) begin
         dir_d = ~dir_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_q  <= SW_RST;
         dir_q <= DIR_RST;
      end else begin
         sw_q  <= sw_d;
         dir_q <= dir_d;
      end
   end

   assign sw  = sw_q;
   assign dir = dir_q;

endmodule

// File: tb/tb_key_ctrl.sv
// tb_key_ctrl: directed checks of key_ctrl with short debounce and hold times.
module tb_key_ctrl;

   logic       clk;
   logic       rst_n;
   logic [1:0] key_n;
   logic [1:0] sw;
   logic       dir;
   logic [1:0] key_press;
   logic [1:0] key_long;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   // Pulse counters sampled on the falling edge, away from the active edge.
   int unsigned p0_cnt = 0, p1_cnt = 0, l0_cnt = 0, l1_cnt = 0;
   int unsigned p0_s, l0_s, p1_s, l1_s;

   key_ctrl #(
      .DEBOUNCE_CNT (4),
      .LONG_CNT     (20),
      .CNT_W        (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_n     (key_n),
      .sw        (sw),
      .dir       (dir),
      .key_press (key_press),
      .key_long  (key_long)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (key_press[0]) p0_cnt++;
      if (key_press[1]) p1_cnt++;
      if (key_long[0])  l0_cnt++;
      if (key_long[1])  l1_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges, then step 1 time unit past the last edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      p0_s = p0_cnt; l0_s = l0_cnt; p1_s = p1_cnt; l1_s = l1_cnt;
   endtask

   task automatic press_key(input int idx, input int hold);
      key_n[idx] = 1'b0;
      tick(hold);
      key_n[idx] = 1'b1;
      tick(15);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
   endtask

   initial begin
      logic [1:0] e;
      rst_n = 1'b0;
      key_n = 2'b11;
      tick(2);
      check("rst_sw", 32'(sw), 32'h1);
      check("rst_dir", 32'(dir), 32'h1);
      check("rst_press", 32'(key_press), 32'h0);
      check("rst_long", 32'(key_long), 32'h0);
      rst_n = 1'b1;
      snap();
      tick(50);
      check("idle_sw", 32'(sw), 32'h1);
      check("idle_dir", 32'(dir), 32'h1);
      check("idle_pulses", p0_cnt + p1_cnt + l0_cnt + l1_cnt - p0_s - p1_s - l0_s - l1_s, 0);

      // Clean press: pulse appears on the 7th edge after the key is first sampled low.
      snap();
      key_n[0] = 1'b0;
      tick(6);
      check("lat_e6", 32'(key_press), 32'h0);
      tick(1);
      check("lat_e7", 32'(key_press), 32'h1);
      check("lat_sw_e7", 32'(sw), 32'h1);
      tick(1);
      check("lat_e8", 32'(key_press), 32'h0);
      check("lat_sw_e8", 32'(sw), 32'h2);
      tick(2);
      key_n[0] = 1'b1;
      tick(15);
      check("clean_np", p0_cnt - p0_s, 1);
      check("clean_nl", l0_cnt - l0_s, 0);

      // Fast bounce never reaches the debounce count.
      snap();
      for (int i = 0; i < 8; i++) begin
         key_n[0] = 1'b0;
         tick(2);
         key_n[0] = 1'b1;
         tick(2);
      end
      tick(15);
      check("bounce_np", p0_cnt - p0_s, 0);
      check("bounce_sw", 32'(sw), 32'h2);

      // Single-cycle release glitches during a hold: still one press.
      snap();
      key_n[0] = 1'b0; tick(9);
      key_n[0] = 1'b1; tick(1);
      key_n[0] = 1'b0; tick(2);
      key_n[0] = 1'b1; tick(1);
      key_n[0] = 1'b0; tick(3);
      key_n[0] = 1'b1; tick(15);
      check("glitch_np", p0_cnt - p0_s, 1);
      check("glitch_nl", l0_cnt - l0_s, 0);
      check("glitch_sw", 32'(sw), 32'h3);

      // Four presses from reset: 10, 11, 00, 01.
      do_reset();
      check("seq_start", 32'(sw), 32'h1);
      for (int i = 0; i < 4; i++) begin
         press_key(0, 10);
         e = 2'(i + 2);
         check($sformatf("seq_sw%0d", i), 32'(sw), 32'(e));
      end

      // Long hold with a 2-cycle release bounce inside: one press, one long, sw=00.
      snap();
      key_n[0] = 1'b0; tick(15);
      key_n[0] = 1'b1; tick(2);
      key_n[0] = 1'b0; tick(23);
      key_n[0] = 1'b1; tick(15);
      check("long_np", p0_cnt - p0_s, 1);
      check("long_nl", l0_cnt - l0_s, 1);
      check("long_sw", 32'(sw), 32'h0);

      // Both keys on the same edge.
      snap();
      key_n = 2'b00;
      tick(6);
      check("both_e6", 32'(key_press), 32'h0);
      tick(1);
      check("both_e7", 32'(key_press), 32'h3);
      tick(1);
      check("both_sw", 32'(sw), 32'h1);
      check("both_dir", 32'(dir), 32'h0);
      tick(2);
      key_n = 2'b11;
      tick(15);
      check("both_np1", p1_cnt - p1_s, 1);
      check("both_nl1", l1_cnt - l1_s, 0);

      // Reset while key 0 is in PRESS_WAIT, key kept held through release.
      snap();
      key_n[0] = 1'b0;
      tick(4);
      rst_n = 1'b0;
      #1;
      check("midrst_sw", 32'(sw), 32'h1);
      check("midrst_dir", 32'(dir), 32'h1);
      check("midrst_press", 32'(key_press), 32'h0);
      check("midrst_long", 32'(key_long), 32'h0);
      check("midrst_np", p0_cnt - p0_s, 0);
      tick(2);
      rst_n = 1'b1;
      snap();
      tick(15);
      check("rehold_np", p0_cnt - p0_s, 1);
      check("rehold_sw", 32'(sw), 32'h2);
      key_n[0] = 1'b1;
      tick(15);
      check("rehold_nl", l0_cnt - l0_s, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/key_ctrl.md
Name: key_ctrl

Overview:
Push-button front end for the LED rotator. It synchronises and debounces two raw active-low keys, then turns them into a 2-bit speed select and a direction bit that feed the rotator's sw/dir inputs.
- Key 0 steps the speed on each press; a long press of key 0 forces the slowest speed.
- Key 1 toggles the direction.
- Both keys' one-cycle press and long-press pulses are also exported for other consumers.

Parameters:
DEBOUNCE_CNT, 1_000_000, consecutive stable clocks needed to accept a press or release (20 ms at 50 MHz).
LONG_CNT, 50_000_000, clocks held in PRESSED before a long-press pulse is emitted (1 s at 50 MHz).
CNT_W, 32, width of the debounce and hold counters; must hold max(DEBOUNCE_CNT, LONG_CNT).

Ports:
clk  input  1  system clock, single clock domain
rst_n  input  1  asynchronous active-low reset
key_n  input  2  raw push buttons, active-low, asynchronous, bouncing
sw  output  2  speed select to the rotator
dir  output  1  direction to the rotator; 1 = rotate left, 0 = rotate right
key_press  output  2  one-cycle pulse per accepted press, per key
key_long  output  2  one-cycle pulse per long press, per key

Behaviour:
- Reset (async assert, sync release): sw=2'b01, dir=1, key_press=0, key_long=0. Synchroniser flops reset to 1 (released). FSMs reset to IDLE; counters reset to 0.
- Synchroniser: 2-flop per key. The FSM sees k = inverted synchronised key (k=1 means pressed).
- Per-key FSM, one counter cnt:
  - IDLE: if k=1, go to PRESS_WAIT with cnt=0.
  - PRESS_WAIT: if k=0, return to IDLE (bounce rejected, no pulse). Else cnt++. When cnt==DEBOUNCE_CNT-1, go to PRESSED with cnt=0 and pulse key_press.
  - PRESSED: if k=0, go to RELEASE_WAIT with cnt=0. Else the hold counter increments and saturates at LONG_CNT. key_long pulses once, in the cycle the hold counter reaches LONG_CNT-1.
  - RELEASE_WAIT: if k=1, return to PRESSED. The hold counter is preserved, so no new press pulse and no second long pulse. When cnt==DEBOUNCE_CNT-1, go to IDLE; the hold counter clears.
  - The hold counter is a second register per key.
- Latency: for a clean press, key_press is high exactly 2+DEBOUNCE_CNT+1 clock edges after the first edge that samples key_n low.
- Pulse rules: key_press and key_long are registered, single-cycle, and at most one of each per physical press.
- sw update, registered, one cycle after the pulse:
  - key_long[0] sets sw=2'b00. It has priority over key_press[0] in the same cycle, which cannot occur by construction but the priority is still required.
  - Otherwise key_press[0] does sw=sw+1, wrapping 2'b11->2'b00.
- dir update: key_press[1] toggles dir, also one cycle after the pulse.
- Simultaneous keys: the two FSMs are fully independent. Same-cycle pulses update sw and dir in the same cycle.
- Reset mid-press: all state aborts immediately. A key still held after reset release must be fully re-debounced and then produces one press pulse.
- Key held through reset release: treated as a new press; this is intended.

Decomposition:
- Shared package key_pkg holds:
  - the FSM state encoding (IDLE=2'd0, PRESS_WAIT=2'd1, PRESSED=2'd2, RELEASE_WAIT=2'd3);
  - the reset constants SW_RST=2'b01 and DIR_RST=1'b1.
- Sub-module key_debounce:
  - one key's synchroniser, FSM and counters;
  - outputs press/long pulses;
  - instantiated twice with DEBOUNCE_CNT and LONG_CNT passed through.
- The top level holds only the sw and dir registers.

Test Plan (all scenarios use DEBOUNCE_CNT=4, LONG_CNT=20):
- Reset → sw=01, dir=1, all pulses 0. Hold key_n=2'b11 for 50 cycles → no change.
- Clean key0 press held 10 cycles → key_press[0] high for exactly 1 cycle, 7 edges after key_n[0] falls; sw goes 01→10 one cycle later; no key_long.
- key0 toggled low/high every 2 cycles for 30 cycles, then released → zero pulses, sw unchanged. Bounce 1-cycle highs during a hold → still exactly one press pulse.
- Four clean key0 presses starting from sw=01 → sequence 10, 11, 00, 01 (wrap checked).
- key0 held 40 cycles → one key_press[0] then one key_long[0]; final sw=00; only one key_long even with a 2-cycle release bounce inside the hold.
- key0 and key1 pressed on the same edge → press pulses coincide, then sw+1 and dir toggles 1→0 together. Assert rst_n mid-PRESS_WAIT → no pulse, all outputs at reset values immediately.
